jtag_shifter: RTL and testbench

JTAG_SHIFTER -- requirements
Module: jtag_shifter

---
 rtl/jtag_shifter_pkg.sv | 15 +
 rtl/jtag_tck_div.sv | 30 +++
 rtl/jtag_shifter.sv | 111 +++++++++++
 tb/tb_jtag_shifter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_shifter_pkg.sv
// Shared types and constants for the JTAG bit shifter.
package jtag_shifter_pkg;

    localparam int CMD_W          = 8;
    localparam int LEN_W          = 3;
    localparam int CLKDIV_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period counter: pulses tc on the last clk cycle of each CLKDIV-long phase.
module jtag_tck_div
    import jtag_shifter_pkg::*;
#(
    parameter int unsigned CLKDIV = CLKDIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam int unsigned CNT_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKDIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && (cnt == LAST);

    // The counter wraps by itself so back-to-back phases need no reload.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/jtag_shifter.sv
// Shifts up to 8 TMS/TDI bits out on a JTAG header and captures TDO, one command at a time.
module jtag_shifter
    import jtag_shifter_pkg::*;
#(
    parameter int unsigned CLKDIV = CLKDIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [CMD_W-1:0] cmd_tms,
    input  logic [CMD_W-1:0] cmd_tdi,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CMD_W-1:0] rsp_tdo,
    output logic             tck,
    output logic             tms,
    output logic             tdi,
    input  logic             tdo,
    output logic             busy
);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_nxt;
    logic [CMD_W-1:0] tms_q;
    logic [CMD_W-1:0] tdi_q;
    logic             accept;
    logic             phase_end;
    logic             more_bits;

    assign accept    = (state == IDLE) && cmd_valid;
    assign idx_nxt   = idx + LEN_W'(1);
    assign more_bits = (idx < len_q);

    jtag_tck_div #(.CLKDIV(CLKDIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .enable ((state == LOW) || (state == HIGH)),
        .tc     (phase_end)
    );

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = LOW;
            end
            LOW: begin
                if (phase_end) state_nxt = HIGH;
            end
            HIGH: begin
                if (phase_end) state_nxt = more_bits ? LOW : RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tck     <= 1'b0;
            tms     <= 1'b1;
            tdi     <= 1'b0;
            rsp_tdo <= '0;
            idx     <= '0;
            len_q   <= '0;
            tms_q   <= '0;
            tdi_q   <= '0;
        end else begin
            state <= state_nxt;
            tck   <= (state_nxt == HIGH);

            if (accept) begin
                len_q   <= cmd_len;
                tms_q   <= cmd_tms;
                tdi_q   <= cmd_tdi;
                idx     <= '0;
                rsp_tdo <= '0;
                tms     <= cmd_tms[0];
                tdi     <= cmd_tdi[0];
            end

            // TDO is captured on the edge that raises TCK.
            if (state == LOW && phase_end) begin
                rsp_tdo[idx] <= tdo;
            end

            if (state == HIGH && phase_end && more_bits) begin
                idx <= idx_nxt;
                tms <= tms_q[idx_nxt];
                tdi <= tdi_q[idx_nxt];
            end
        end
    end

endmodule

// File: tb/tb_jtag_shifter.sv
// Directed bench for jtag_shifter: one instance at CLKDIV=2, one at CLKDIV=1.
module tb_jtag_shifter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_len = '0;
    logic [7:0] cmd_tms = '0;
    logic [7:0] cmd_tdi = '0;
    logic       rsp_ready = 1'b0;
    logic       tdo_drv = 1'b0;
    logic       loop_en = 1'b0;
    logic       sel = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic       cmd_ready2, rsp_valid2, tck2, tms2, tdi2, busy2;
    logic [7:0] rsp_tdo2;
    logic       cmd_ready1, rsp_valid1, tck1, tms1, tdi1, busy1;
    logic [7:0] rsp_tdo1;

    logic       cmd_ready, rsp_valid, tck, tms, tdi, busy, tdo;
    logic [7:0] rsp_tdo;

    assign cmd_ready = sel ? cmd_ready1 : cmd_ready2;
    assign rsp_valid = sel ? rsp_valid1 : rsp_valid2;
    assign rsp_tdo   = sel ? rsp_tdo1   : rsp_tdo2;
    assign tck       = sel ? tck1       : tck2;
    assign tms       = sel ? tms1       : tms2;
    assign tdi       = sel ? tdi1       : tdi2;
    assign busy      = sel ? busy1      : busy2;
    assign tdo       = loop_en ? tdi : tdo_drv;

    always #5 clk = ~clk;

    jtag_shifter #(.CLKDIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready2),
        .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo2),
        .tck(tck2), .tms(tms2), .tdi(tdi2), .tdo(tdo), .busy(busy2)
    );

    jtag_shifter #(.CLKDIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready1),
        .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo1),
        .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdo), .busy(busy1)
    );

    // Presents a command, waits for acceptance, then records pin activity until rsp_valid.
    task automatic send_cmd(input logic [2:0] len, input logic [7:0] tms_v, input logic [7:0] tdi_v,
                            output int cycles, output int rises, output int tms_hi,
                            output int tdi_bad, output logic [63:0] trace, output bit timeout);
        int   n;
        logic prev_tck;
        logic prev_tdi;
        cmd_len   = len;
        cmd_tms   = tms_v;
        cmd_tdi   = tdi_v;
        cmd_valid = 1'b1;
        timeout   = 1'b0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (!cmd_ready) timeout = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cycles = 0; rises = 0; tms_hi = 0; tdi_bad = 0; trace = '0;
        prev_tck = 1'b0;
        prev_tdi = tdi;
        while (!rsp_valid && cycles < 600) begin
            if (cycles < 64) trace[cycles] = tck;
            if (tck && !prev_tck) begin
                rises++;
                if (tms) tms_hi++;
            end
            if (tdi !== prev_tdi && tck) tdi_bad++;
            prev_tck = tck;
            prev_tdi = tdi;
            @(posedge clk); #1; cycles++;
        end
        if (!rsp_valid) timeout = 1'b1;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tck !== 1'b0) begin n_fail++; $display("FAIL reset tck: got %b expected 0", tck); end
        n_checks++; if (tms !== 1'b1) begin n_fail++; $display("FAIL reset tms: got %b expected 1", tms); end
        n_checks++; if (tdi !== 1'b0) begin n_fail++; $display("FAIL reset tdi: got %b expected 0", tdi); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_tdo !== 8'h00) begin n_fail++; $display("FAIL reset rsp_tdo: got %h expected 00", rsp_tdo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready: got %b expected 1", cmd_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_bit();
        int cyc, rises, tms_hi, tdi_bad; logic [63:0] trace; bit to;
        tdo_drv = 1'b1;
        send_cmd(3'd0, 8'h01, 8'h00, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL single_bit timeout: got %b expected 0", to); end
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL single_bit latency: got %0d expected 4", cyc); end
        n_checks++; if (trace[3:0] !== 4'b1100) begin n_fail++; $display("FAIL single_bit tck trace: got %b expected 1100", trace[3:0]); end
        n_checks++; if (rises !== 1) begin n_fail++; $display("FAIL single_bit tck pulses: got %0d expected 1", rises); end
        n_checks++; if (rsp_tdo !== 8'h01) begin n_fail++; $display("FAIL single_bit rsp_tdo: got %h expected 01", rsp_tdo); end
        n_checks++; if (tck !== 1'b0) begin n_fail++; $display("FAIL single_bit resp tck: got %b expected 0", tck); end
        finish_rsp();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_bit rsp_valid after handshake: got %b expected 0", rsp_valid); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_bit cmd_ready in idle: got %b expected 1", cmd_ready); end
        n_checks++; if (tms !== 1'b1) begin n_fail++; $display("FAIL single_bit tms hold: got %b expected 1", tms); end
        tdo_drv = 1'b0;
    endtask

    task automatic test_tap_reset();
        int cyc, rises, tms_hi, tdi_bad; logic [63:0] trace; bit to;
        rsp_ready = 1'b1;
        send_cmd(3'd4, 8'h1F, 8'h00, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL tap_reset timeout: got %b expected 0", to); end
        n_checks++; if (cyc !== 20) begin n_fail++; $display("FAIL tap_reset cycles: got %0d expected 20", cyc); end
        n_checks++; if (rises !== 5) begin n_fail++; $display("FAIL tap_reset tck pulses: got %0d expected 5", rises); end
        n_checks++; if (tms_hi !== 5) begin n_fail++; $display("FAIL tap_reset tms high at rise: got %0d expected 5", tms_hi); end
        @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL tap_reset rsp_valid one cycle: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tap_reset busy: got %b expected 0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_loopback();
        int cyc, rises, tms_hi, tdi_bad; logic [63:0] trace; bit to;
        loop_en = 1'b1;
        send_cmd(3'd7, 8'h00, 8'hA5, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL loopback timeout: got %b expected 0", to); end
        n_checks++; if (rsp_tdo !== 8'hA5) begin n_fail++; $display("FAIL loopback rsp_tdo: got %h expected a5", rsp_tdo); end
        n_checks++; if (tdi_bad !== 0) begin n_fail++; $display("FAIL loopback tdi change while tck high: got %0d expected 0", tdi_bad); end
        n_checks++; if (cyc !== 32) begin n_fail++; $display("FAIL loopback cycles: got %0d expected 32", cyc); end
        n_checks++; if (rises !== 8) begin n_fail++; $display("FAIL loopback tck pulses: got %0d expected 8", rises); end
        finish_rsp();
        n_checks++; if (tdi !== 1'b1) begin n_fail++; $display("FAIL loopback tdi hold in idle: got %b expected 1", tdi); end
        loop_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int cyc, rises, tms_hi, tdi_bad; logic [63:0] trace; bit to;
        tdo_drv = 1'b1;
        send_cmd(3'd1, 8'h00, 8'h03, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL backpressure timeout: got %b expected 0", to); end
        cmd_len = 3'd0; cmd_tms = 8'h00; cmd_tdi = 8'h01; cmd_valid = 1'b1;
        tdo_drv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL backpressure rsp_valid cyc %0d: got %b expected 1", i, rsp_valid); end
            n_checks++; if (rsp_tdo !== 8'h03) begin n_fail++; $display("FAIL backpressure rsp_tdo cyc %0d: got %h expected 03", i, rsp_tdo); end
            n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure cmd_ready cyc %0d: got %b expected 0", i, cmd_ready); end
            @(posedge clk); #1;
        end
        finish_rsp();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL backpressure accepted in resp: busy got %b expected 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL backpressure rsp_valid after handshake: got %b expected 0", rsp_valid); end
        send_cmd(3'd0, 8'h00, 8'h01, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL backpressure second cmd cycles: got %0d expected 4", cyc); end
        n_checks++; if (rsp_tdo !== 8'h00) begin n_fail++; $display("FAIL backpressure second rsp_tdo: got %h expected 00", rsp_tdo); end
        finish_rsp();
    endtask

    task automatic test_reset_mid_shift();
        int tck_seen;
        int rsp_seen;
        cmd_len = 3'd7; cmd_tms = 8'h00; cmd_tdi = 8'hFF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        // Bit 3 HIGH phase starts (2*3+1)*CLKDIV = 14 edges after acceptance.
        repeat (14) @(posedge clk);
        #1;
        n_checks++; if (tck !== 1'b1) begin n_fail++; $display("FAIL mid_reset in bit3 high: tck got %b expected 1", tck); end
        n_checks++; if (tdi !== 1'b1) begin n_fail++; $display("FAIL mid_reset pre tdi: got %b expected 1", tdi); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (tck !== 1'b0) begin n_fail++; $display("FAIL mid_reset tck: got %b expected 0", tck); end
        n_checks++; if (tms !== 1'b1) begin n_fail++; $display("FAIL mid_reset tms: got %b expected 1", tms); end
        n_checks++; if (tdi !== 1'b0) begin n_fail++; $display("FAIL mid_reset tdi: got %b expected 0", tdi); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset rsp_valid: got %b expected 0", rsp_valid); end
        tck_seen = 0; rsp_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tck) tck_seen++;
            if (rsp_valid) rsp_seen++;
        end
        n_checks++; if (tck_seen !== 0) begin n_fail++; $display("FAIL mid_reset tck after abort: got %0d expected 0", tck_seen); end
        n_checks++; if (rsp_seen !== 0) begin n_fail++; $display("FAIL mid_reset response after abort: got %0d expected 0", rsp_seen); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_clkdiv1();
        int cyc, rises, tms_hi, tdi_bad; logic [63:0] trace; bit to;
        sel = 1'b1;
        tdo_drv = 1'b1;
        #1;
        send_cmd(3'd2, 8'h00, 8'hFF, cyc, rises, tms_hi, tdi_bad, trace, to);
        n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL clkdiv1 timeout: got %b expected 0", to); end
        n_checks++; if (cyc !== 6) begin n_fail++; $display("FAIL clkdiv1 cycles: got %0d expected 6", cyc); end
        n_checks++; if (trace[5:0] !== 6'b101010) begin n_fail++; $display("FAIL clkdiv1 tck trace: got %b expected 101010", trace[5:0]); end
        n_checks++; if (rises !== 3) begin n_fail++; $display("FAIL clkdiv1 tck pulses: got %0d expected 3", rises); end
        n_checks++; if (rsp_tdo !== 8'h07) begin n_fail++; $display("FAIL clkdiv1 rsp_tdo: got %h expected 07", rsp_tdo); end
        finish_rsp();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clkdiv1 busy after handshake: got %b expected 0", busy); end
        tdo_drv = 1'b0;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_tap_reset();
        test_loopback();
        test_backpressure();
        test_reset_mid_shift();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
